ring_freq_meter: RTL and testbench
==================================

Name: ring_freq_meter

Overview:
- Next-generation ring oscillator block: the multi-ring top is generalised to N_RINGS selectable rings, with on-chip frequency measurement replacing raw clock outputs.
- Selected ring output is treated as asynchronous data: synchronised into clk, rising-edge detected, and counted over a programmable window of clk cycles.
- Supports single-shot and continuous modes.
- Sits between the ring array and the top-level IO; result is readable as a full word or one byte at a time.

Parameters:
- N_RINGS, 6, number of ring inputs.
- SEL_W, 3, width of ring select; must satisfy 2**SEL_W >= N_RINGS.
- WIN_W, 16, width of the window-length counter.
- CNT_W, 16, width of the edge counter.
- SYNC_STAGES, 2, synchroniser depth on the muxed ring signal; minimum 2.

Ports:
- clk  in  1  sole clock, system/reference clock.
- rst_n  in  1  asynchronous active-low reset.
- ring_in  in  N_RINGS  raw ring oscillator outputs, asynchronous to clk.
- sel  in  SEL_W  ring select; sampled only on an accepted start.
- start  in  1  level; sampled each cycle; accepted only in IDLE.
- continuous  in  1  sampled on start; also sampled at each DONE.
- win_len  in  WIN_W  window length in clk cycles; sampled on start; 0 is treated as 1.
- byte_sel  in  1  readout byte select: 0 = count[7:0], 1 = count[15:8] (upper bits zero if CNT_W<16).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a new result is latched.
- count  out  CNT_W  last latched edge count.
- overflow  out  1  last latched window saturated.
- data_out  out  8  byte of count chosen by byte_sel, combinational from registered count.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - busy=0, done=0, count=0, overflow=0.
  - Synchroniser, edge register, window and edge counters all 0.
- Ring mux: sel_q >= N_RINGS selects constant 0, so the measurement completes with count=0.
- Synchroniser: SYNC_STAGES flops on the muxed ring signal, plus one edge register. A rising edge is counted when sync_out=1 and the previous value was 0.
- Measurable rate: the ring must toggle no faster than clk/2 for accurate counts. Faster rings alias; this is documented, not detected.
- FSM:
  - IDLE: on start=1, capture sel_q, win_q=max(win_len,1) and cont_q; go to SETTLE.
  - SETTLE: SYNC_STAGES+1 cycles to flush stale synchroniser data. No counting. Then clear the edge counter and load the window counter with win_q; go to MEASURE.
  - MEASURE: window counter decrements each cycle; edge counter increments on each detected edge. Edge counter saturates at all-ones, and sat_flag is set when an increment is attempted at all-ones. The last cycle is when the window counter equals 1; that cycle's edge is included. Go to DONE.
  - DONE (1 cycle): count<=edge counter, overflow<=sat_flag, done=1.
    - If cont_q && continuous: clear counters, reload the window with win_q, go directly to MEASURE (no resettle, sel unchanged).
    - Otherwise go to IDLE.
- Latency:
  - Single-shot: start accepted at cycle 0, first MEASURE cycle at cycle SYNC_STAGES+2, done at cycle SYNC_STAGES+2+win_q.
  - Continuous: result period is win_q+1 cycles.
- start while busy: ignored. sel, win_len and byte_sel changes while busy do not affect the run in progress.
- Dropping continuous mid-window: the current window finishes and reports, then the FSM returns to IDLE.
- count/overflow hold their value between done pulses.
- Reset mid-operation: immediate return to the reset state; the partial count is discarded.

Decomposition:
- Shared package ring_pkg:
  - FSM state enum (IDLE, SETTLE, MEASURE, DONE).
  - Default N_RINGS/CNT_W constants.
  - Ring stage-count list (5, 11, 23, 47, 97, 197) for the top that instantiates the rings.
- One sub-module: ring_sync_edge (SYNC_STAGES synchroniser plus rising-edge detect, parameter SYNC_STAGES).
- Counters and FSM stay in ring_freq_meter.

Test Plan:
- Reset: assert rst_n=0 mid-MEASURE -> busy=0, count=0, overflow=0, done=0 immediately; no done pulse after release.
- Single-shot: bench drives ring_in[2] toggling every 4 clk (period 8), sel=2, win_len=64, SYNC_STAGES=2 -> done exactly 68 cycles after start, count=8 (+/-1 for phase), byte_sel=0 gives data_out=8.
- Continuous: same stimulus, continuous=1 for 3 windows, then 0 -> done pulses 65 cycles apart, each count=8; exactly one more done after deassert, then busy=0.
- Saturation: CNT_W=4, ring period 4, win_len=100 -> count=15, overflow=1. A following run with win_len=8 gives overflow=0, count=2.
- Boundaries:
  - win_len=0 -> behaves as 1; done 5 cycles after start.
  - sel=7 with N_RINGS=6 -> count=0.
  - start asserted while busy -> no extra run.
- Readout: count=0x1234 latched -> data_out=0x34 with byte_sel=0, 0x12 with byte_sel=1. Changing byte_sel alters nothing else.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared definitions for the ring oscillator frequency meter and the
// ring-array top that feeds it.
package ring_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int N_RINGS_DEF     = 6;
  localparam int SEL_W_DEF       = 3;
  localparam int WIN_W_DEF       = 16;
  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

  // Inverter count of each ring in the array, indexed by ring number.
  function automatic int ring_stages(input int idx);
    case (idx)
      0:       return 5;
      1:       return 11;
      2:       return 23;
      3:       return 47;
      4:       return 97;
      5:       return 197;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/ring_sync_edge.sv
// Synchroniser for the asynchronous muxed ring signal followed by a
// rising-edge detector in the clk domain.
module ring_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  if (SYNC_STAGES < 2) begin : g_bad_depth
    $error("ring_sync_edge: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/ring_freq_meter.sv
// Selects one ring oscillator, synchronises it into clk and counts its rising
// edges over a programmable window; single-shot or back-to-back windows.
module ring_freq_meter
  import ring_pkg::*;
#(
  parameter int N_RINGS     = N_RINGS_DEF,
  parameter int SEL_W       = SEL_W_DEF,
  parameter int WIN_W       = WIN_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_RINGS-1:0] ring_in,
  input  logic [SEL_W-1:0]   sel,
  input  logic               start,
  input  logic               continuous,
  input  logic [WIN_W-1:0]   win_len,
  input  logic               byte_sel,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   count,
  output logic               overflow,
  output logic [7:0]         data_out
);

  if ((2 ** SEL_W) < N_RINGS) begin : g_bad_sel_w
    $error("ring_freq_meter: SEL_W too narrow for N_RINGS");
  end

  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

  state_t               r_state, w_state_nxt;
  logic [SEL_W-1:0]     r_sel_q;
  logic [WIN_W-1:0]     r_win_q;
  logic                 r_cont_q;
  logic [SETTLE_W-1:0]  r_settle;
  logic [WIN_W-1:0]     r_win;
  logic [CNT_W-1:0]     r_edge_cnt;
  logic                 r_sat;
  logic [CNT_W-1:0]     r_count;
  logic                 r_ovf;
  logic                 r_done;

  logic                 w_ring_mux;
  logic                 w_rise;
  logic [CNT_W-1:0]     w_edge_cnt_nxt;
  logic                 w_sat_nxt;
  logic                 w_last;
  logic                 w_cont_go;
  logic [15:0]          w_cnt16;

  // Out-of-range selects read as a constant 0 ring.
  always_comb begin
    w_ring_mux = 1'b0;
    for (int i = 0; i < N_RINGS; i++) begin
      if (r_sel_q == SEL_W'(i)) w_ring_mux = ring_in[i];
    end
  end

  ring_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (w_ring_mux),
    .o_rise  (w_rise)
  );

  always_comb begin
    w_edge_cnt_nxt = r_edge_cnt;
    w_sat_nxt      = r_sat;
    if (w_rise) begin
      if (&r_edge_cnt) w_sat_nxt = 1'b1;
      else             w_edge_cnt_nxt = r_edge_cnt + 1'b1;
    end
  end

  assign w_last    = (r_win == WIN_W'(1));
  assign w_cont_go = r_cont_q & continuous;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_nxt = ST_SETTLE;
      ST_SETTLE:  if (r_settle == '0) w_state_nxt = ST_MEASURE;
      ST_MEASURE: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = w_cont_go ? ST_MEASURE : ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Result is latched on the last MEASURE edge so count is valid while done=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_q    <= '0;
      r_win_q    <= '0;
      r_cont_q   <= 1'b0;
      r_settle   <= '0;
      r_win      <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sel_q  <= sel;
            r_win_q  <= (win_len == '0) ? WIN_W'(1) : win_len;
            r_cont_q <= continuous;
            r_settle <= SETTLE_W'(SYNC_STAGES);
          end
        end
        ST_SETTLE: begin
          if (r_settle != '0) begin
            r_settle <= r_settle - 1'b1;
          end else begin
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
            r_win      <= r_win_q;
          end
        end
        ST_MEASURE: begin
          r_edge_cnt <= w_edge_cnt_nxt;
          r_sat      <= w_sat_nxt;
          r_win      <= r_win - 1'b1;
          if (w_last) begin
            r_count <= w_edge_cnt_nxt;
            r_ovf   <= w_sat_nxt;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (w_cont_go) begin
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
            r_win      <= r_win_q;
          end
        end
        default: ;
      endcase
    end
  end

  if (CNT_W >= 16) begin : g_cnt_wide
    assign w_cnt16 = r_count[15:0];
  end else begin : g_cnt_narrow
    assign w_cnt16 = {{(16 - CNT_W){1'b0}}, r_count};
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign count    = r_count;
  assign overflow = r_ovf;
  assign data_out = byte_sel ? w_cnt16[15:8] : w_cnt16[7:0];

endmodule

// File: tb/tb_ring_freq_meter.sv
// Bench for ring_freq_meter: clk-synchronous ring models, a results scoreboard
// per instance, a vector table of single-shot runs and hand-written sequences.
module tb_ring_freq_meter;

  localparam int LIM = 20000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] ring_in = '0;

  logic       start = 1'b0, continuous = 1'b0, byte_sel = 1'b0;
  logic [2:0] sel = '0;
  logic [15:0] win_len = '0;
  logic       busy, done, overflow;
  logic [15:0] count;
  logic [7:0] data_out;

  logic       b_start = 1'b0, b_cont = 1'b0, b_byte_sel = 1'b0;
  logic [2:0] b_sel = 3'd1;
  logic [15:0] b_win = '0;
  logic       b_busy, b_done, b_ovf;
  logic [3:0] b_count;
  logic [7:0] b_data;

  typedef struct { logic [15:0] cnt; logic ovf; } exp_t;
  typedef struct { logic [2:0] sel; logic [15:0] win; logic [15:0] cnt; int lat; } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk = 0, n_fail = 0, n_done_a = 0, n_done_b = 0;
  int   half [6] = '{1, 2, 4, 3, 5, 0};
  int   hcnt [6] = '{0, 0, 0, 0, 0, 0};

  ring_freq_meter u_dut (
    .clk(clk), .rst_n(rst_n), .ring_in(ring_in), .sel(sel), .start(start),
    .continuous(continuous), .win_len(win_len), .byte_sel(byte_sel),
    .busy(busy), .done(done), .count(count), .overflow(overflow), .data_out(data_out)
  );

  ring_freq_meter #(.CNT_W(4)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .ring_in(ring_in), .sel(b_sel), .start(b_start),
    .continuous(b_cont), .win_len(b_win), .byte_sel(b_byte_sel),
    .busy(b_busy), .done(b_done), .count(b_count), .overflow(b_ovf), .data_out(b_data)
  );

  always #5 clk = ~clk;

  // Ring i toggles every half[i] clk cycles; half=0 holds the ring at 0.
  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (half[i] != 0) begin
        hcnt[i] = hcnt[i] + 1;
        if (hcnt[i] >= half[i]) begin
          ring_in[i] = ~ring_in[i];
          hcnt[i] = 0;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      n_done_a++;
      if (qa.size() == 0) begin
        check("unexpected_done_a", 32'd1, 32'd0);
      end else begin
        e = qa.pop_front();
        check("count_a", 32'(count), 32'(e.cnt));
        check("overflow_a", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_done) begin
      exp_t e;
      n_done_b++;
      if (qb.size() == 0) begin
        check("unexpected_done_b", 32'd1, 32'd0);
      end else begin
        e = qb.pop_front();
        check("count_b", 32'(b_count), 32'(e.cnt));
        check("overflow_b", 32'(b_ovf), 32'(e.ovf));
      end
    end
  end

  // Advance on negedges until the chosen done is high or the budget runs out.
  task automatic wait_done(input bit use_b, input int n0, output int n);
    n = n0;
    while (!(use_b ? b_done : done) && n < LIM) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_a(input logic [2:0] s, input logic [15:0] w, input logic [15:0] ec,
                       input logic eo, input int el, input string nm);
    int n;
    @(negedge clk);
    sel = s; win_len = w; continuous = 1'b0; start = 1'b1;
    qa.push_back('{ec, eo});
    @(negedge clk);
    start = 1'b0; sel = 3'd6; win_len = 16'hffff;
    wait_done(1'b0, 1, n);
    check({nm, "_latency"}, 32'(n), 32'(el));
    @(negedge clk);
    check({nm, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic run_b(input logic [15:0] w, input logic [3:0] ec, input logic eo,
                       input int el, input string nm);
    int n;
    @(negedge clk);
    b_win = w; b_start = 1'b1;
    qb.push_back('{16'(ec), eo});
    @(negedge clk);
    b_start = 1'b0;
    wait_done(1'b1, 1, n);
    check({nm, "_latency"}, 32'(n), 32'(el));
  endtask

  initial begin
    vec_t vt [6];
    int   n, nd;

    vt[0] = '{3'd2, 16'd64, 16'd8,  68};
    vt[1] = '{3'd5, 16'd0,  16'd0,  5};
    vt[2] = '{3'd7, 16'd16, 16'd0,  20};
    vt[3] = '{3'd0, 16'd10, 16'd5,  14};
    vt[4] = '{3'd3, 16'd60, 16'd10, 64};
    vt[5] = '{3'd4, 16'd50, 16'd5,  54};

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vt[i]) run_a(vt[i].sel, vt[i].win, vt[i].cnt, 1'b0, vt[i].lat, $sformatf("vec%0d", i));
    byte_sel = 1'b0;
    #1 check("vec_data_out", 32'(data_out), 32'h05);

    // Three continuous windows, then one more after continuous drops mid-window.
    repeat (4) qa.push_back('{16'd8, 1'b0});
    @(negedge clk);
    sel = 3'd2; win_len = 16'd64; continuous = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, 1, n);
    check("cont_first_latency", 32'(n), 32'd68);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      wait_done(1'b0, 1, n);
      check("cont_period", 32'(n), 32'd65);
    end
    repeat (10) @(negedge clk);
    continuous = 1'b0;
    wait_done(1'b0, 10, n);
    check("cont_last_period", 32'(n), 32'd65);
    @(negedge clk);
    check("cont_busy_after", 32'(busy), 32'd0);
    nd = n_done_a;
    repeat (100) @(negedge clk);
    check("cont_no_extra_done", 32'(n_done_a - nd), 32'd0);

    // A second start mid-run must be ignored.
    nd = n_done_a;
    qa.push_back('{16'd0, 1'b0});
    @(negedge clk);
    sel = 3'd7; win_len = 16'd30; start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 1;
    repeat (4) begin @(negedge clk); n++; end
    sel = 3'd2; win_len = 16'd64; start = 1'b1;
    @(negedge clk);
    start = 1'b0; n++;
    wait_done(1'b0, n, n);
    check("busy_start_latency", 32'(n), 32'd34);
    repeat (100) @(negedge clk);
    check("busy_start_one_run", 32'(n_done_a - nd), 32'd1);
    check("busy_start_idle", 32'(busy), 32'd0);

    // Byte readout of 0x1234 edges from the clk/2 ring.
    run_a(3'd0, 16'd9320, 16'h1234, 1'b0, 9324, "readout");
    byte_sel = 1'b0;
    #1 check("readout_lo", 32'(data_out), 32'h34);
    byte_sel = 1'b1;
    #1 check("readout_hi", 32'(data_out), 32'h12);
    check("readout_count_hold", 32'(count), 32'h1234);
    check("readout_busy", 32'(busy), 32'd0);
    byte_sel = 1'b0;

    // Saturation on the 4-bit instance, then a clean run.
    run_b(16'd100, 4'd15, 1'b1, 104, "sat");
    run_b(16'd8, 4'd2, 1'b0, 12, "unsat");
    b_byte_sel = 1'b0;
    #1 check("sat_data_lo", 32'(b_data), 32'h02);
    b_byte_sel = 1'b1;
    #1 check("sat_data_hi", 32'(b_data), 32'h00);

    // Reset in the middle of a measurement window.
    @(negedge clk);
    sel = 3'd2; win_len = 16'd64; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    nd = n_done_a;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("post_rst_no_done", 32'(n_done_a - nd), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("scoreboard_a_empty", 32'(qa.size()), 32'd0);
    check("scoreboard_b_empty", 32'(qb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
